stepper_move_queue: RTL
=======================

Name: stepper_move_queue

Overview:
- Move-command FIFO and sequencer that sits directly upstream of the CoreXY stepper driver.
- Accepts paired (step, speed) move records from the HPS bridge and holds them in a FIFO.
- Presents one record at a time on the driver's step/speed inputs, pulses start_driving, then waits for steppers_driving to fall before issuing the next move.
- Keeps back-to-back moves flowing without an HPS round-trip per move.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries of 128 bits).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  push one move record this cycle.
- wr_step_1  in  32  motor 1 steps, sign-magnitude: bit31 = direction, [30:0] = count.
- wr_speed_1  in  32  motor 1 half-period in clk cycles.
- wr_step_2  in  32  motor 2 steps, same format as wr_step_1.
- wr_speed_2  in  32  motor 2 half-period in clk cycles.
- flush  in  1  discard all queued (not yet issued) moves.
- pause  in  1  inhibit issuing new moves.
- steppers_driving  in  1  busy flag from the driver.
- stepper_step_in_1  out  32  to driver.
- stepper_speed_1  out  32  to driver.
- stepper_step_in_2  out  32  to driver.
- stepper_speed_2  out  32  to driver.
- start_driving  out  1  one-cycle start pulse to driver.
- full  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  DEPTH_LOG2+1  current entry count.
- overflow  out  1  sticky; a write was dropped.
- busy  out  1  state != IDLE.
- moves_done  out  32  completed plus skipped moves since reset; wraps modulo 2^32.

Behaviour:
- Reset values: all outputs 0 except empty=1. FIFO pointers 0, state IDLE.
- FIFO: circular buffer, registered pointers.
  - full, empty and level are registered and reflect the pointers after each edge.
  - Push when wr_en=1 and full=0 (full as sampled this cycle).
  - Push while full=1: record dropped, overflow<=1. This holds even if a pop occurs in the same cycle.
  - Simultaneous push and pop (not full, not empty): level unchanged.
  - Pointers wrap modulo depth.
- flush: pointers reset, level<=0, overflow<=0.
  - flush wins over wr_en in the same cycle: write dropped, overflow not set.
  - Does not affect the state machine or output registers; an in-flight move completes normally.
- State IDLE:
  - Pops the head entry when empty=0, pause=0, flush=0 and steppers_driving=0.
  - Zero move (head step_1[30:0]==0 and step_2[30:0]==0): pop, moves_done++, stay IDLE, outputs unchanged, no start pulse.
  - Otherwise: latch head into the four output registers, go to START.
  - Speed clamp on latch: a speed field of 0 is latched as 1.
- State START: start_driving=1 for exactly this cycle; outputs stable. Go to ACK.
- State ACK: one cycle, covering driver latch latency. steppers_driving is ignored. Go to RUN.
- State RUN: when steppers_driving==0, moves_done++ and go to IDLE.
- Output registers hold the last issued move until the next issue.
- Latency: wr_en at cycle N into empty idle queue → start_driving high at cycle N+2. Next move's start_driving comes no earlier than 2 cycles after steppers_driving falls.
- pause: checked only in IDLE; raising it mid-move lets the current move finish.
- Reset mid-move: FSM forced to IDLE, FIFO emptied, outputs 0.
  - The driver may still be running; IDLE will not pop until steppers_driving=0.
- Endstop-terminated moves: still end by steppers_driving falling and count as done. No special handling.

Test Plan:
- Single move: reset, push (step1=0x0000000A, speed1=4, step2=0x8000000A, speed2=4) at cycle 10 → start_driving high only at cycle 12 with those values; driver model busy 80 cycles → moves_done=1, busy=0.
- Fill/overflow: with pause=1, push 17 records → full=1, level=16, overflow=1, 17th lost. Release pause → exactly 16 start pulses in FIFO order.
- Zero-move skip: push (0,5,0x80000000,5) then (3,2,3,2) → no pulse for the first, moves_done=1 immediately. One pulse for the second; moves_done=2 after it completes.
- Speed clamp: push speed1=0, speed2=7 → stepper_speed_1=1, stepper_speed_2=7 at start_driving.
- Flush mid-move: 3 queued, first running, assert flush plus wr_en same cycle → level=0, overflow=0, no further starts. Running move completes; moves_done=1.
- Reset mid-move: reset while steppers_driving=1 with 2 queued → all outputs 0, empty=1. No start_driving until after steppers_driving falls and a new push arrives.

Source files
------------

// File: rtl/stepper_move_queue.sv
// Move-record FIFO feeding the CoreXY stepper driver: queues (step, speed) pairs and
// issues them one at a time, waiting for the driver to go idle between moves.
module stepper_move_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [31:0]           wr_step_1,
  input  logic [31:0]           wr_speed_1,
  input  logic [31:0]           wr_step_2,
  input  logic [31:0]           wr_speed_2,
  input  logic                  flush,
  input  logic                  pause,
  input  logic                  steppers_driving,
  output logic [31:0]           stepper_step_in_1,
  output logic [31:0]           stepper_speed_1,
  output logic [31:0]           stepper_step_in_2,
  output logic [31:0]           stepper_speed_2,
  output logic                  start_driving,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  busy,
  output logic [31:0]           moves_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_ACK   = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Record layout: {speed_2, step_2, speed_1, step_1}
  logic [127:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_level;
  logic                    r_full;
  logic                    r_empty;
  logic                    r_overflow;
  logic [31:0]             r_step_1;
  logic [31:0]             r_speed_1;
  logic [31:0]             r_step_2;
  logic [31:0]             r_speed_2;
  logic [31:0]             r_moves_done;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_issue;
  logic                    w_done_inc;
  logic [127:0]            w_head;
  logic                    w_head_zero;
  logic [DEPTH_LOG2:0]     w_level_nxt;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_zero = (w_head[30:0] == 31'd0) && (w_head[94:64] == 31'd0);
  assign w_push      = wr_en && !r_full && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_done_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Waiting on steppers_driving also covers a driver still running after reset.
        if (!r_empty && !pause && !flush && !steppers_driving) begin
          w_pop = 1'b1;
          if (w_head_zero) begin
            w_done_inc = 1'b1;
          end else begin
            w_issue     = 1'b1;
            w_state_nxt = S_START;
          end
        end
      end
      S_START: w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_RUN;
      S_RUN: begin
        if (!steppers_driving) begin
          w_done_inc  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {wr_speed_2, wr_step_2, wr_speed_1, wr_step_1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_FULL);
      r_empty <= (w_level_nxt == '0);
      // A write against a full queue is dropped even if a pop frees a slot this cycle.
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_step_1     <= '0;
      r_speed_1    <= '0;
      r_step_2     <= '0;
      r_speed_2    <= '0;
      r_moves_done <= '0;
    end else begin
      if (w_issue) begin
        r_step_1  <= w_head[31:0];
        r_speed_1 <= (w_head[63:32] == 32'd0) ? 32'd1 : w_head[63:32];
        r_step_2  <= w_head[95:64];
        r_speed_2 <= (w_head[127:96] == 32'd0) ? 32'd1 : w_head[127:96];
      end
      if (w_done_inc) begin
        r_moves_done <= r_moves_done + 32'd1;
      end
    end
  end

  assign stepper_step_in_1 = r_step_1;
  assign stepper_speed_1   = r_speed_1;
  assign stepper_step_in_2 = r_step_2;
  assign stepper_speed_2   = r_speed_2;
  assign start_driving     = (r_state == S_START);
  assign full              = r_full;
  assign empty             = r_empty;
  assign level             = r_level;
  assign overflow          = r_overflow;
  assign busy              = (r_state != S_IDLE);
  assign moves_done        = r_moves_done;

endmodule
